// File: rtl/uart_reg_cmd_parser_if.sv
// Byte-in / register-strobe-out bundle for uart_reg_cmd_parser.
// i_dv is a one-cycle byte strobe with no backpressure; every high cycle consumes i_data.
`timescale 1ns/1ps
interface uart_reg_cmd_parser_if #(
   parameter int WORD_WIDTH = 8,
   parameter int REG_WIDTH  = 4,
   parameter int REG_DEPTH  = 16
);
   localparam int ADDR_W = $clog2(REG_DEPTH);

   logic [WORD_WIDTH-1:0]           i_data;
   logic                            i_dv;
   logic                            o_w_en;
   logic [ADDR_W-1:0]               o_w_addr;
   logic [WORD_WIDTH*REG_WIDTH-1:0] o_w_value;
   logic                            o_r_en;
   logic [ADDR_W-1:0]               o_r_addr;
   logic                            o_err;
   logic                            o_busy;
   logic [7:0]                      o_err_cnt;
   logic                            dbg_state;

   modport slave (
      input  i_data, i_dv,
      output o_w_en, o_w_addr, o_w_value, o_r_en, o_r_addr,
             o_err, o_busy, o_err_cnt, dbg_state
   );

   modport master (
      output i_data, i_dv,
      input  o_w_en, o_w_addr, o_w_value, o_r_en, o_r_addr,
             o_err, o_busy, o_err_cnt, dbg_state
   );
endinterface

// File: rtl/uart_reg_cmd_parser.sv
// Turns UART bytes into register read/write strobes: header (rw flag + address),
// then REG_WIDTH data bytes for writes. Bad addresses and mid-frame stalls are dropped.
`timescale 1ns/1ps
module uart_reg_cmd_parser #(
   parameter int WORD_WIDTH    = 8,
   parameter int REG_WIDTH     = 4,
   parameter int REG_DEPTH     = 16,
   parameter int LITTLE_ENDIAN = 0,
   parameter int TIMEOUT       = 100000
) (
   input  logic                  clk,
   input  logic                  i_reset,
   uart_reg_cmd_parser_if.slave  bus
);
   localparam int ADDR_W = $clog2(REG_DEPTH);
   localparam int VAL_W  = WORD_WIDTH * REG_WIDTH;
   localparam int CNT_W  = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
   localparam int IDLE_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(REG_WIDTH - 1);
   localparam logic [IDLE_W-1:0]     IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);
   localparam logic [WORD_WIDTH-1:0] DEPTH_W    = WORD_WIDTH'(REG_DEPTH);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDLE_W-1:0]     idle_q, idle_d;
   logic [ADDR_W-1:0]     lat_addr_q, lat_addr_d;
   logic [VAL_W-1:0]      shreg_q, shreg_d;
   logic                  w_en_q, w_en_d;
   logic [ADDR_W-1:0]     w_addr_q, w_addr_d;
   logic [VAL_W-1:0]      w_value_q, w_value_d;
   logic                  r_en_q, r_en_d;
   logic [ADDR_W-1:0]     r_addr_q, r_addr_d;
   logic                  err_q, err_d;
   logic [7:0]            err_cnt_q, err_cnt_d;

   logic [WORD_WIDTH-2:0] hdr_addr;
   logic                  hdr_rw;
   logic                  hdr_bad;
   logic                  raise_err;
   int                    slot;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idle_d     = idle_q;
      lat_addr_d = lat_addr_q;
      shreg_d    = shreg_q;
      w_en_d     = 1'b0;
      w_addr_d   = w_addr_q;
      w_value_d  = w_value_q;
      r_en_d     = 1'b0;
      r_addr_d   = r_addr_q;
      err_d      = 1'b0;
      err_cnt_d  = err_cnt_q;
      raise_err  = 1'b0;

      hdr_addr = bus.i_data[WORD_WIDTH-2:0];
      hdr_rw   = bus.i_data[WORD_WIDTH-1];
      hdr_bad  = {1'b0, hdr_addr} >= DEPTH_W;
      // Big-endian puts the first byte in the top slot, little-endian in slot 0.
      slot = (LITTLE_ENDIAN != 0) ? int'(cnt_q) : (REG_WIDTH - 1 - int'(cnt_q));

      case (state_q)
         ST_IDLE: begin
            idle_d = '0;
            if (bus.i_dv) begin
               if (hdr_bad) begin
                  raise_err = 1'b1;
               end else if (!hdr_rw) begin
                  r_en_d   = 1'b1;
                  r_addr_d = hdr_addr[ADDR_W-1:0];
               end else begin
                  lat_addr_d = hdr_addr[ADDR_W-1:0];
                  shreg_d    = '0;
                  cnt_d      = '0;
                  state_d    = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (bus.i_dv) begin
               idle_d = '0;
               shreg_d[slot*WORD_WIDTH +: WORD_WIDTH] = bus.i_data;
               if (cnt_q == LAST_CNT) begin
                  w_en_d    = 1'b1;
                  w_addr_d  = lat_addr_q;
                  w_value_d = shreg_d;
                  cnt_d     = '0;
                  state_d   = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (idle_q == IDLE_LIMIT) begin
               // A byte on this cycle would have won; only a true stall expires.
               raise_err = 1'b1;
               idle_d    = '0;
               cnt_d     = '0;
               state_d   = ST_IDLE;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (raise_err) begin
         err_d = 1'b1;
         if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idle_q     <= '0;
         lat_addr_q <= '0;
         shreg_q    <= '0;
         w_en_q     <= 1'b0;
         w_addr_q   <= '0;
         w_value_q  <= '0;
         r_en_q     <= 1'b0;
         r_addr_q   <= '0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idle_q     <= idle_d;
         lat_addr_q <= lat_addr_d;
         shreg_q    <= shreg_d;
         w_en_q     <= w_en_d;
         w_addr_q   <= w_addr_d;
         w_value_q  <= w_value_d;
         r_en_q     <= r_en_d;
         r_addr_q   <= r_addr_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.o_w_en    = w_en_q;
   assign bus.o_w_addr  = w_addr_q;
   assign bus.o_w_value = w_value_q;
   assign bus.o_r_en    = r_en_q;
   assign bus.o_r_addr  = r_addr_q;
   assign bus.o_err     = err_q;
   assign bus.o_busy    = (state_q == ST_DATA);
   assign bus.o_err_cnt = err_cnt_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_uart_reg_cmd_parser.sv
// Directed bench for uart_reg_cmd_parser: big- and little-endian instances share one
// byte stream; a monitor pops expected strobe events from per-instance queues.
`timescale 1ns/1ps
module tb_uart_reg_cmd_parser;
   localparam int EV_W = 38;

   logic       clk;
   logic       i_reset;
   logic       i_dv;
   logic [7:0] i_data;

   int n_chk = 0;
   int n_err = 0;
   int exp_err_cnt = 0;

   logic [EV_W-1:0] exp_be[$];
   logic [EV_W-1:0] exp_le[$];
   logic [EV_W-1:0] be_exp_ev, le_exp_ev;

   uart_reg_cmd_parser_if be_if ();
   uart_reg_cmd_parser_if le_if ();

   assign be_if.i_dv   = i_dv;
   assign be_if.i_data = i_data;
   assign le_if.i_dv   = i_dv;
   assign le_if.i_data = i_data;

   uart_reg_cmd_parser #(.LITTLE_ENDIAN(0), .TIMEOUT(50)) dut_be (
      .clk(clk), .i_reset(i_reset), .bus(be_if.slave));
   uart_reg_cmd_parser #(.LITTLE_ENDIAN(1), .TIMEOUT(50)) dut_le (
      .clk(clk), .i_reset(i_reset), .bus(le_if.slave));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] bswap(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [EV_W-1:0] ev_of(input logic w, input logic r,
                                             input logic [3:0] wa, input logic [31:0] wv,
                                             input logic [3:0] ra);
      if (w) return {2'd1, wa, wv};
      if (r) return {2'd2, ra, 32'd0};
      return {2'd3, 4'd0, 32'd0};
   endfunction

   // driver tasks: each cycle ends 1 time unit after the active edge
   task automatic drive_cycle(input logic dv, input logic [7:0] d);
      i_dv   = dv;
      i_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      drive_cycle(1'b1, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00);
   endtask

   task automatic push_write(input logic [3:0] a, input logic [31:0] v);
      exp_be.push_back({2'd1, a, v});
      exp_le.push_back({2'd1, a, bswap(v)});
   endtask

   task automatic push_read(input logic [3:0] a);
      exp_be.push_back({2'd2, a, 32'd0});
      exp_le.push_back({2'd2, a, 32'd0});
   endtask

   task automatic push_err();
      exp_be.push_back({2'd3, 4'd0, 32'd0});
      exp_le.push_back({2'd3, 4'd0, 32'd0});
      if (exp_err_cnt < 255) exp_err_cnt++;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_w_en"},    be_if.o_w_en,     0);
      check({tag, "_r_en"},    be_if.o_r_en,     0);
      check({tag, "_err"},     be_if.o_err,      0);
      check({tag, "_busy"},    be_if.o_busy,     0);
      check({tag, "_w_addr"},  be_if.o_w_addr,   0);
      check({tag, "_w_value"}, be_if.o_w_value,  0);
      check({tag, "_r_addr"},  be_if.o_r_addr,   0);
      check({tag, "_err_cnt"}, be_if.o_err_cnt,  0);
      check({tag, "_le_w_value"}, le_if.o_w_value, 0);
      check({tag, "_le_err_cnt"}, le_if.o_err_cnt, 0);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (i_reset && (be_if.o_w_en || be_if.o_r_en || be_if.o_err)) begin
         check("be_strobe_excl", 64'(int'(be_if.o_w_en) + int'(be_if.o_r_en) + int'(be_if.o_err)), 1);
         if (exp_be.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL be_unexpected_event: got %0h expected none",
                     ev_of(be_if.o_w_en, be_if.o_r_en, be_if.o_w_addr, be_if.o_w_value, be_if.o_r_addr));
         end else begin
            be_exp_ev = exp_be.pop_front();
            check("be_event", ev_of(be_if.o_w_en, be_if.o_r_en, be_if.o_w_addr,
                                    be_if.o_w_value, be_if.o_r_addr), be_exp_ev);
         end
      end
      if (i_reset && (le_if.o_w_en || le_if.o_r_en || le_if.o_err)) begin
         check("le_strobe_excl", 64'(int'(le_if.o_w_en) + int'(le_if.o_r_en) + int'(le_if.o_err)), 1);
         if (exp_le.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL le_unexpected_event: got %0h expected none",
                     ev_of(le_if.o_w_en, le_if.o_r_en, le_if.o_w_addr, le_if.o_w_value, le_if.o_r_addr));
         end else begin
            le_exp_ev = exp_le.pop_front();
            check("le_event", ev_of(le_if.o_w_en, le_if.o_r_en, le_if.o_w_addr,
                                    le_if.o_w_value, le_if.o_r_addr), le_exp_ev);
         end
      end
   end

   // stimulus
   initial begin
      i_reset = 1'b0;
      i_dv    = 1'b0;
      i_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      i_reset = 1'b1;
      idle(2);

      // big/little-endian write to addr 3
      push_write(4'd3, 32'hDEADBEEF);
      send_byte(8'h83);
      check("wr_busy_after_hdr", be_if.o_busy, 1);
      send_byte(8'hDE);
      send_byte(8'hAD);
      send_byte(8'hBE);
      check("wr_busy_mid", be_if.o_busy, 1);
      check("wr_no_strobe_mid", be_if.o_w_en, 0);
      send_byte(8'hEF);
      check("wr_w_en", be_if.o_w_en, 1);
      check("wr_busy_fall", be_if.o_busy, 0);
      check("wr_w_addr", be_if.o_w_addr, 3);
      check("wr_w_value_be", be_if.o_w_value, 32'hDEADBEEF);
      check("wr_w_value_le", le_if.o_w_value, 32'hEFBEADDE);
      idle(2);
      check("wr_w_en_single", be_if.o_w_en, 0);
      check("wr_w_value_held", be_if.o_w_value, 32'hDEADBEEF);

      // read then bad address
      push_read(4'd5);
      send_byte(8'h05);
      check("rd_r_en", be_if.o_r_en, 1);
      check("rd_r_addr", be_if.o_r_addr, 5);
      check("rd_busy", be_if.o_busy, 0);
      push_err();
      send_byte(8'h90);
      check("bad_err", be_if.o_err, 1);
      check("bad_r_en", be_if.o_r_en, 0);
      check("bad_w_en", be_if.o_w_en, 0);
      check("bad_busy", be_if.o_busy, 0);
      check("bad_err_cnt", be_if.o_err_cnt, 1);
      check("bad_r_addr_held", be_if.o_r_addr, 5);
      idle(1);

      // 49 idle cycles inside a frame: still accepted
      push_write(4'd1, 32'h11223344);
      send_byte(8'h81);
      send_byte(8'h11);
      idle(49);
      check("gap49_busy", be_if.o_busy, 1);
      check("gap49_no_err", be_if.o_err, 0);
      send_byte(8'h22);
      check("gap49_accepted", be_if.o_busy, 1);
      send_byte(8'h33);
      send_byte(8'h44);
      check("gap49_w_en", be_if.o_w_en, 1);
      check("gap49_w_value_be", be_if.o_w_value, 32'h11223344);
      check("gap49_w_value_le", le_if.o_w_value, 32'h44332211);
      idle(1);

      // 50 idle cycles: timeout, frame discarded
      send_byte(8'h81);
      send_byte(8'h55);
      push_err();
      idle(49);
      check("gap50_pre_busy", be_if.o_busy, 1);
      idle(1);
      check("to_err", be_if.o_err, 1);
      check("to_busy_fall", be_if.o_busy, 0);
      check("to_w_value_held", be_if.o_w_value, 32'h11223344);
      check("to_err_cnt", be_if.o_err_cnt, 64'(exp_err_cnt));
      push_read(4'd2);
      send_byte(8'h02);
      check("to_then_read", be_if.o_r_en, 1);
      check("to_then_read_addr", be_if.o_r_addr, 2);
      idle(2);

      // back-to-back write then read, zero gap
      push_write(4'd1, 32'h01020304);
      push_read(4'd1);
      send_byte(8'h81);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      check("b2b_w_en", be_if.o_w_en, 1);
      send_byte(8'h01);
      check("b2b_r_en", be_if.o_r_en, 1);
      check("b2b_w_en_off", be_if.o_w_en, 0);
      check("b2b_r_addr", be_if.o_r_addr, 1);
      idle(2);

      // reset mid-frame
      send_byte(8'h87);
      send_byte(8'hAA);
      send_byte(8'hBB);
      i_reset = 1'b0;
      #1;
      check_all_zero("midrst");
      exp_err_cnt = 0;
      idle(2);
      i_reset = 1'b1;
      idle(1);
      push_write(4'd7, 32'hCAFEF00D);
      send_byte(8'h87);
      send_byte(8'hCA);
      send_byte(8'hFE);
      send_byte(8'hF0);
      send_byte(8'h0D);
      check("post_rst_w_en", be_if.o_w_en, 1);
      check("post_rst_w_addr", be_if.o_w_addr, 7);
      check("post_rst_w_value_be", be_if.o_w_value, 32'hCAFEF00D);
      check("post_rst_w_value_le", le_if.o_w_value, 32'h0DF0FECA);
      check("post_rst_err_cnt", be_if.o_err_cnt, 0);
      idle(2);

      // error counter saturation
      for (int i = 0; i < 300; i++) begin
         push_err();
         send_byte((i % 2 == 1) ? 8'h90 : 8'hC0);
      end
      idle(3);
      check("sat_err_cnt_be", be_if.o_err_cnt, 64'(exp_err_cnt));
      check("sat_err_cnt_le", le_if.o_err_cnt, 255);
      check("sat_idle_busy", be_if.o_busy, 0);

      idle(3);
      check("be_queue_drained", 64'(exp_be.size()), 0);
      check("le_queue_drained", 64'(exp_le.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/uart_reg_cmd_parser.md
# uart_reg_cmd_parser

Byte-stream command parser between `uart_rx` and `register_block`. It turns received UART bytes into addressed register write and read strobes, replacing the fixed-address deserializer path. A frame is a header byte (R/W flag plus address), followed by `REG_WIDTH` data bytes for writes only. Malformed frames are dropped: bad address, or an inter-byte timeout mid-frame.

## Interface
- `WORD_WIDTH`, 8: bits per received byte; header MSB is the R/W flag, low `WORD_WIDTH-1` bits are the address.
- `REG_WIDTH`, 4: data bytes per register (≥1).
- `REG_DEPTH`, 16: number of registers; `ADDR_W = $clog2(REG_DEPTH)`, must be ≤ `WORD_WIDTH-1`.
- `LITTLE_ENDIAN`, 0: 0 = first data byte lands in the MS byte; 1 = first data byte lands in the LS byte.
- `TIMEOUT`, 100000: idle clocks allowed between bytes inside a write frame (≥2).

Ports:
- `clk` in 1: clock.
- `i_reset` in 1: reset, asynchronous, active-low.
- `i_data` in `WORD_WIDTH`: received byte, valid when `i_dv`=1.
- `i_dv` in 1: byte strobe; every high cycle consumes one byte.
- `o_w_en` out 1: one-cycle register write strobe.
- `o_w_addr` out `ADDR_W`: write address, held until the next write.
- `o_w_value` out `WORD_WIDTH*REG_WIDTH`: write data, held until the next write.
- `o_r_en` out 1: one-cycle register read strobe.
- `o_r_addr` out `ADDR_W`: read address, held until the next read.
- `o_err` out 1: one-cycle error strobe (bad address or timeout).
- `o_busy` out 1: high while inside a write frame (state DATA).
- `o_err_cnt` out 8: saturating error count (stops at 255).

## Operation
- States:
  - IDLE: waiting for a header.
  - DATA: collecting write bytes; a byte counter `cnt` runs 0..`REG_WIDTH-1`.
- Header handling (IDLE, `i_dv`=1). Let `addr = i_data[WORD_WIDTH-2:0]`, `rw = i_data[WORD_WIDTH-1]`.
  - `addr ≥ REG_DEPTH`: pulse `o_err`, increment `o_err_cnt`, stay in IDLE. This applies to both R and W.
  - `rw`=0 (read): load `o_r_addr`, pulse `o_r_en`, stay in IDLE.
  - `rw`=1 (write): latch the address internally, clear the shift register, set `cnt`=0, go to DATA.
- Data handling (DATA, `i_dv`=1):
  - Place the byte in its slot according to `LITTLE_ENDIAN`, then increment `cnt`.
  - On the byte with `cnt`=`REG_WIDTH-1`: load `o_w_addr`/`o_w_value`, pulse `o_w_en`, return to IDLE.
- Timeout:
  - An idle counter clears on every `i_dv` and counts clocks in DATA while `i_dv`=0.
  - When it reaches `TIMEOUT`: pulse `o_err`, increment `o_err_cnt`, discard the partial frame, return to IDLE. `o_w_*` are left unchanged.
  - A byte arriving on the same cycle the counter would expire is accepted; the timeout does not fire.
- IDLE never times out.
- `o_w_en`, `o_r_en` and `o_err` are mutually exclusive in any cycle.

## Timing
- All outputs are registered.
  - `o_r_en` asserts 1 cycle after the header's `i_dv`.
  - `o_w_en` asserts 1 cycle after the last data byte's `i_dv`.
  - `o_err` asserts 1 cycle after the offending header's `i_dv`, or 1 cycle after expiry.
- `o_busy` goes high the cycle after a valid write header and low the same cycle `o_w_en` or the timeout `o_err` asserts.
- Back-to-back frames: a header may arrive on the cycle immediately after a frame's final byte. Zero gap is supported; no byte is lost.
- `i_dv` held high for k cycles consumes k bytes; the upstream pulse stage guarantees single-cycle strobes.
- Reset (asynchronous, any time, including mid-frame):
  - State returns to IDLE; `cnt` and the idle counter clear.
  - All outputs go to 0: `o_w_en`, `o_r_en`, `o_err`, `o_busy`, `o_w_addr`, `o_w_value`, `o_r_addr`, `o_err_cnt`.
  - A partial frame is discarded silently, with no `o_err`.

## Test plan
Defaults unless stated; `TIMEOUT`=50 in the bench.
- Write, big-endian: bytes 0x83, 0xDE, 0xAD, 0xBE, 0xEF → one `o_w_en` pulse 1 cycle after 0xEF, with `o_w_addr`=3 and `o_w_value`=0xDEADBEEF; `o_busy` high between header and strobe.
- Write, little-endian (`LITTLE_ENDIAN`=1): same bytes → `o_w_value`=0xEFBEADDE.
- Read and bad address: 0x05 → `o_r_en` pulse with `o_r_addr`=5. Then 0x90 (addr 16) → `o_err` pulse, `o_err_cnt`=1, no `o_r_en`/`o_w_en`, state stays IDLE.
- Timeout boundary: send 0x81, 0x11, then a gap.
  - Next byte after a gap of exactly 49 idle cycles → accepted, frame continues.
  - Gap of 50 idle cycles → `o_err`, `o_busy` falls, `o_w_value` unchanged; a following 0x02 is parsed as a read header.
- Back-to-back frames: write frame to addr 1 immediately followed (0 gap) by read header 0x01 → `o_w_en` then `o_r_en` on consecutive cycles.
- Reset mid-frame: assert `i_reset`=0 after 2 data bytes → all outputs 0, no `o_err`. After release, a full write to addr 7 completes correctly.
- Error saturation: 300 bad headers → `o_err_cnt` stops at 255.
